// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage feeding the opcode decoder / control unit.
// Holds the PC, reads instruction words over a req/ack handshake, latches
// them and presents the split fields to decode with valid/ready. A HALT
// opcode (4'hF) stops fetching until reset.
// Optional feature macro: INSTR_FETCH_JUMP_EN. When it is defined, opcode
// 4'hE is an absolute jump that is consumed here and never presented.
module instr_fetch #(
  parameter int                    PC_WIDTH    = 8,
  parameter int                    INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ack,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [3:0]             opcode,
  output logic [3:0]             rd,
  output logic [3:0]             rs1,
  output logic [3:0]             rs2,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   halted
);

  localparam logic [3:0] OP_HALT = 4'hF;
`ifdef INSTR_FETCH_JUMP_EN
  localparam logic [3:0] OP_JUMP = 4'hE;
`endif

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] ir;

  // Address is the PC itself; it only moves on an accepted fetch, so it is
  // stable for the whole time a request is outstanding.
  assign imem_addr = pc;

  assign opcode = ir[15:12];
  assign rd     = ir[11:8];
  assign rs1    = ir[7:4];
  assign rs2    = ir[3:0];

  // Fetch/issue sequencer; all handshake outputs are registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET;
      pc          <= RESET_PC;
      ir          <= '0;
      instr_pc    <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end

        S_FETCH: begin
          // Without an ack, req and pc simply hold.
          if (imem_ack) begin
            ir       <= imem_rdata;
            instr_pc <= pc;
            imem_req <= 1'b0;
            state    <= S_ISSUE;
`ifdef INSTR_FETCH_JUMP_EN
            // A jump is swallowed: redirect the PC and spend one idle
            // cycle in ISSUE with valid low.
            if (imem_rdata[15:12] == OP_JUMP) begin
              pc          <= PC_WIDTH'(imem_rdata[7:0]);
              instr_valid <= 1'b0;
            end else begin
              pc          <= pc + PC_WIDTH'(1);
              instr_valid <= 1'b1;
            end
`else
            pc          <= pc + PC_WIDTH'(1);
            instr_valid <= 1'b1;
`endif
          end
        end

        S_ISSUE: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            // HALT is still handed to decode; fetching stops afterwards.
            if (ir[15:12] == OP_HALT) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end
          end
`ifdef INSTR_FETCH_JUMP_EN
          else if (!instr_valid) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
`endif
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state <= S_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed protocol steps followed by randomized
// memory latency / decode backpressure, checked against a program-order
// reference model of what should be fetched and presented.
module tb_instr_fetch;

  localparam int          PW  = 8;
  localparam logic [7:0]  RPC = 8'hFF;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  opcode, rd, rs1, rs2;
  logic [7:0]  instr_pc;
  logic        halted;

  instr_fetch #(.PC_WIDTH(PW), .INSTR_WIDTH(16), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .instr_pc(instr_pc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory image and stimulus policy
  logic [15:0] mem [256];
  int wcnt, fix_dly;
  bit rnd_dly, rnd_rdy, fix_rdy, noise;

  // reference model: next address to fetch, presented word, halt status
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [7:0]  m_ipc;
  bit          m_pend, m_halted;

  int tests, fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++)
      mem[i] = {4'($urandom_range(0, 13)), 12'($urandom)};
  endtask

  task automatic model_reset();
    m_pc = RPC; m_pend = 0; m_halted = 0; m_ir = '0; m_ipc = '0;
  endtask

  // One accepted memory read, in program-order terms.
  task automatic model_fetch();
    logic [15:0] w;
    w = mem[m_pc];
`ifdef INSTR_FETCH_JUMP_EN
    if (w[15:12] == 4'hE) begin
      m_pc = w[7:0];
      return;
    end
`endif
    m_ir  = w;
    m_ipc = m_pc;
    m_pend = 1;
    m_pc  = m_pc + 8'd1;
  endtask

  task automatic score();
    chk("halted", halted, m_halted);
    chk("req_and_valid", imem_req & instr_valid, 0);
    if (m_halted) chk("halt_quiet", imem_req | instr_valid, 0);
    if (imem_req) begin
      chk("fetch_addr", imem_addr, m_pc);
      if (imem_ack) model_fetch();
    end
    if (instr_valid) begin
      chk("valid_expected", m_pend, 1);
      chk("fields", {opcode, rd, rs1, rs2}, m_ir);
      chk("instr_pc", instr_pc, m_ipc);
      if (instr_ready) begin
        m_pend = 0;
        if (m_ir[15:12] == 4'hF) m_halted = 1;
      end
    end
  endtask

  // Drive inputs on the falling edge, score, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    if (imem_req) begin
      if (wcnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr];
        wcnt = rnd_dly ? int'($urandom_range(0, 3)) : fix_dly;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        wcnt--;
      end
    end else begin
      imem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = 16'($urandom);
    end
    instr_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : fix_rdy;
    if (rst) model_reset();
    else     score();
    @(posedge clk);
    #1;
  endtask

  int n;
  logic [7:0] a;

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    wcnt = 0; fix_dly = 0; rnd_dly = 0; rnd_rdy = 0; fix_rdy = 1; noise = 1;
    model_reset();
    fill_mem();
    mem[8'hFF] = 16'h2000; mem[8'h00] = 16'h0123; mem[8'h01] = 16'hE042;
    mem[8'h02] = 16'h1456; mem[8'h42] = 16'h1456; mem[8'h50] = 16'hF000;

    // reset state (acks toggling during reset must be ignored)
    tick(); tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_fields", {opcode, rd, rs1, rs2}, 0);

    // first fetch from RESET_PC, zero-wait memory
    rst = 1'b0; wcnt = 0;
    tick();
    chk("lat_req", imem_req, 1);
    chk("lat_addr", imem_addr, 8'hFF);
    tick();
    chk("first_valid", instr_valid, 1);
    chk("first_ipc", instr_pc, 8'hFF);
    chk("first_fields", {opcode, rd, rs1, rs2}, 16'h2000);
    tick();
    chk("wrap_req", imem_req, 1);
    chk("wrap_addr", imem_addr, 8'h00);
    tick();
    chk("i0_fields", {opcode, rd, rs1, rs2}, 16'h0123);
    chk("i0_ipc", instr_pc, 8'h00);
    tick();
    chk("i1_addr", imem_addr, 8'h01);

    // opcode E at address 1
    tick();
`ifdef INSTR_FETCH_JUMP_EN
    chk("jump_hidden", instr_valid, 0);
    chk("jump_noreq", imem_req, 0);
    a = 8'h42;
`else
    chk("e_presented", instr_valid, 1);
    chk("e_fields", {opcode, rd, rs1, rs2}, 16'hE042);
    a = 8'h02;
`endif

    // ack delayed three cycles: request held four cycles
    wcnt = 3;
    tick();
    fix_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, a);
      chk("wait_novalid", instr_valid, 0);
      tick();
    end
    chk("late_valid", instr_valid, 1);
    chk("late_ipc", instr_pc, a);

    // decode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", instr_valid, 1);
      chk("stall_noreq", imem_req, 0);
      chk("stall_fields", {opcode, rd, rs1, rs2}, 16'h1456);
    end
    fix_rdy = 1;
    tick();
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, a + 8'd1);

    // randomized latency/backpressure until HALT at 0x50
    rnd_dly = 1; rnd_rdy = 1;
    n = 0;
    while (!halted && n < 4000) begin tick(); n++; end
    chk("halt_reached", halted, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_noreq", imem_req, 0);
      chk("halt_hold", halted, 1);
    end

    // reset leaves HALT; then reset lands on a cycle with an ack
    rst = 1'b1;
    tick();
    chk("unhalt", halted, 0);
    chk("unhalt_req", imem_req, 0);
    rst = 1'b0; rnd_dly = 0; fix_dly = 0; wcnt = 0; rnd_rdy = 0;
    tick();
    chk("refetch_addr", imem_addr, RPC);
    rst = 1'b1;
    tick();
    chk("midfetch_rst_req", imem_req, 0);
    chk("midfetch_rst_valid", instr_valid, 0);
    chk("midfetch_rst_ipc", instr_pc, 0);
    rst = 1'b0;
    tick();
    chk("after_rst_req", imem_req, 1);
    chk("after_rst_addr", imem_addr, RPC);
    tick();
    chk("after_rst_ipc", instr_pc, RPC);

    // second random program, HALT placed past the wrap point
    fill_mem();
    mem[$urandom_range(16, 200)] = {4'hF, 12'($urandom)};
    rnd_dly = 1; rnd_rdy = 1;
    n = 0;
    while (!halted && n < 6000) begin tick(); n++; end
    chk("halt2_reached", halted, 1);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage directly upstream of the opcode decoder/control unit.
- Holds the program counter and issues word reads to instruction memory over a req/ack handshake.
- Latches the returned instruction and presents its split fields (opcode, rd, rs1, rs2) to decode with a valid/ready handshake.
- Stops fetching permanently on a HALT opcode, until reset.

Parameters:
PC_WIDTH, 8, program counter / imem address width (PC wraps modulo 2^PC_WIDTH)
INSTR_WIDTH, 16, instruction word width; fixed at 16 for the field map below
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  read request to instruction memory
imem_addr  out  PC_WIDTH  read address, equals pc while imem_req=1
imem_rdata  in  INSTR_WIDTH  read data, sampled only when imem_ack=1 and imem_req=1
imem_ack  in  1  read completion; may arrive 0..N cycles after imem_req rises
instr_valid  out  1  instruction fields valid toward decode
instr_ready  in  1  decode accepts the current instruction
opcode  out  4  IR[15:12], feeds control unit opcode input
rd  out  4  IR[11:8]
rs1  out  4  IR[7:4]
rs2  out  4  IR[3:0]
instr_pc  out  PC_WIDTH  address the presented instruction was fetched from
halted  out  1  high once a HALT instruction has been accepted

Behaviour:
Clock and reset:
- One clock (clk); rst is synchronous, active-high.
- Reset values: state=RESET, pc=RESET_PC, IR=0, imem_req=0, instr_valid=0, halted=0, instr_pc=0, all fields 0.

State machine (Moore outputs; IR, pc and instr_pc registered):
- RESET: entered on reset; no request. Next cycle -> FETCH.
- FETCH: imem_req=1, imem_addr=pc. imem_ack=1 -> capture IR<=imem_rdata, instr_pc<=pc, pc<=pc+1 (wrap at 2^PC_WIDTH), go to ISSUE. imem_ack=0 -> stay, holding req and addr stable.
- ISSUE: imem_req=0, instr_valid=1, fields stable. On instr_ready=1:
  - opcode==4'b1111 (HALT) -> HALT.
  - otherwise -> FETCH.
  - instr_ready=0 -> stay; fields and instr_valid held unchanged.
- HALT: instr_valid=0, imem_req=0, halted=1. Stays until rst.

Timing:
- Earliest throughput is one instruction per 2 cycles with zero-wait memory: ack seen in FETCH, instruction accepted in ISSUE.
- Latency from reset release to first instr_valid is 2 cycles with ack in the first FETCH cycle.

Boundary conditions:
- imem_ack while imem_req=0 (RESET, ISSUE, HALT) is ignored; IR and pc are unchanged.
- pc=2^PC_WIDTH-1 fetched -> pc becomes 0; no flag.
- rst asserted in any state, including mid-FETCH with an ack pending, overrides everything that cycle. A late ack arriving in the following RESET cycle is dropped.
- The HALT instruction itself is presented and handed to decode. The control unit's default case treats it as a no-write.
- instr_ready while instr_valid=0 has no effect.

Optional Feature:
Macro: INSTR_FETCH_JUMP_EN.
Defined:
- Opcode 4'b1110 is an absolute jump, target = zero-extended IR[7:0] truncated to PC_WIDTH.
- The jump is consumed internally: on the cycle after capture it is never presented (instr_valid stays 0). pc<=target and state -> FETCH, so one cycle is spent in ISSUE with valid=0.
Undefined:
- 4'b1110 is an ordinary instruction, presented to decode like any other.
- pc advances sequentially.

Test Plan:
- Reset, imem always acks same cycle with rdata=16'h0123 at addr 0 and instr_ready=1 -> imem_req high in cycle 1; instr_valid in cycle 2 with opcode=0, rd=1, rs1=2, rs2=3, instr_pc=0; next imem_addr=1.
- Ack delayed 3 cycles at addr 5 -> imem_req/imem_addr=5 held stable 4 cycles; instr_valid only after ack; pc=6 afterwards.
- instr_ready=0 for 5 cycles while instr_valid=1 (IR=16'h1456) -> fields constant, no imem_req; on ready=1 next cycle FETCH starts.
- RESET_PC=8'hFF, data 16'h2000 -> instr_pc=FF, next imem_addr=00.
- Fetch 16'hF000 at addr 3, accept -> halted=1 next cycle, imem_req stays 0 for 20 cycles; assert rst -> halted=0, refetch from RESET_PC.
- With INSTR_FETCH_JUMP_EN, 16'hE042 at addr 1 -> no instr_valid for it, next imem_addr=8'h42. Without the macro -> presented as opcode=E, rd=0, rs1=4, rs2=2, next imem_addr=2.
